// File: rtl/csr_unit.sv
// LA32 privileged CSR file with exception/ERTN commit, LLBit and stable timer.
// Timer CSRs (TID/TCFG/TVAL/TICLR) exist only when CSR_TIMER_EN is defined.
module csr_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] csr_raddr_i,
    output logic [31:0] csr_rdata_o,
    output logic [1:0]  cpu_level_o,
    input  logic        csr_we_i,
    input  logic [13:0] csr_waddr_i,
    input  logic [31:0] csr_wdata_i,
    input  logic        llbit_we_i,
    input  logic        llbit_wdata_i,
    input  logic        excep_en_i,
    input  logic [5:0]  excep_ecode_i,
    input  logic [8:0]  excep_esubcode_i,
    input  logic [31:0] excep_pc_i,
    input  logic        excep_badv_we_i,
    input  logic [31:0] excep_badv_wdata_i,
    input  logic        ertn_en_i,
    input  logic [7:0]  hw_int_i,
    output logic        int_req_o,
    output logic [31:0] excep_entry_o,
    output logic [31:0] ertn_pc_o,
    output logic        llbit_o
);
    localparam logic [13:0] A_CRMD   = 14'h000;
    localparam logic [13:0] A_PRMD   = 14'h001;
    localparam logic [13:0] A_ECFG   = 14'h004;
    localparam logic [13:0] A_ESTAT  = 14'h005;
    localparam logic [13:0] A_ERA    = 14'h006;
    localparam logic [13:0] A_BADV   = 14'h007;
    localparam logic [13:0] A_EENTRY = 14'h00C;
    localparam logic [13:0] A_SAVE0  = 14'h030;
    localparam logic [13:0] A_SAVE1  = 14'h031;
    localparam logic [13:0] A_SAVE2  = 14'h032;
    localparam logic [13:0] A_SAVE3  = 14'h033;
    localparam logic [13:0] A_TID    = 14'h040;
    localparam logic [13:0] A_TCFG   = 14'h041;
    localparam logic [13:0] A_TVAL   = 14'h042;
    localparam logic [13:0] A_TICLR  = 14'h044;
    localparam logic [13:0] A_LLBCTL = 14'h060;
    localparam logic [12:0] ECFG_MASK = 13'h1BFF;

    logic [8:0]       crmd;      // {DATM, DATF, PG, DA, IE, PLV}
    logic [2:0]       prmd;      // {PIE, PPLV}
    logic [12:0]      ecfg;
    logic [1:0]       is_sw;
    logic [7:0]       is_hw;
    logic [5:0]       ecode;
    logic [8:0]       esubcode;
    logic [31:0]      era;
    logic [31:0]      badv;
    logic [25:0]      eentry;
    logic [3:0][31:0] save;
    logic             llbit;
    logic             klo;
    logic             timer_is;
    logic [12:0]      is_all;

    logic wr_crmd, wr_prmd, wr_ecfg, wr_estat, wr_era, wr_badv, wr_eentry;
    logic wr_save, wr_llbctl;

    assign wr_crmd   = csr_we_i && (csr_waddr_i == A_CRMD);
    assign wr_prmd   = csr_we_i && (csr_waddr_i == A_PRMD);
    assign wr_ecfg   = csr_we_i && (csr_waddr_i == A_ECFG);
    assign wr_estat  = csr_we_i && (csr_waddr_i == A_ESTAT);
    assign wr_era    = csr_we_i && (csr_waddr_i == A_ERA);
    assign wr_badv   = csr_we_i && (csr_waddr_i == A_BADV);
    assign wr_eentry = csr_we_i && (csr_waddr_i == A_EENTRY);
    assign wr_save   = csr_we_i && (csr_waddr_i[13:2] == A_SAVE0[13:2]);
    assign wr_llbctl = csr_we_i && (csr_waddr_i == A_LLBCTL);

`ifdef CSR_TIMER_EN
    logic [31:0] tid;
    logic [31:0] tcfg;           // {InitVal[31:2], Periodic, En}
    logic [31:0] tval;
    logic        timer_en;
    logic        wr_tid, wr_tcfg, wr_ticlr;

    assign wr_tid   = csr_we_i && (csr_waddr_i == A_TID);
    assign wr_tcfg  = csr_we_i && (csr_waddr_i == A_TCFG);
    assign wr_ticlr = csr_we_i && (csr_waddr_i == A_TICLR) && csr_wdata_i[0];
`else
    assign timer_is = 1'b0;
`endif

    assign is_all = {1'b0, timer_is, 1'b0, is_hw, is_sw};

    // Later assignments override earlier ones: csr write < ERTN < exception.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crmd     <= 9'h008;
            prmd     <= '0;
            ecfg     <= '0;
            is_sw    <= '0;
            is_hw    <= '0;
            ecode    <= '0;
            esubcode <= '0;
            era      <= '0;
            badv     <= '0;
            eentry   <= '0;
            save     <= '0;
            llbit    <= 1'b0;
            klo      <= 1'b0;
`ifdef CSR_TIMER_EN
            tid      <= '0;
            tcfg     <= '0;
            tval     <= '0;
            timer_en <= 1'b0;
            timer_is <= 1'b0;
`endif
        end else begin
            is_hw <= hw_int_i;

            if (wr_crmd)   crmd   <= csr_wdata_i[8:0];
            if (wr_prmd)   prmd   <= csr_wdata_i[2:0];
            if (wr_ecfg)   ecfg   <= csr_wdata_i[12:0] & ECFG_MASK;
            if (wr_estat)  is_sw  <= csr_wdata_i[1:0];
            if (wr_era)    era    <= csr_wdata_i;
            if (wr_badv)   badv   <= csr_wdata_i;
            if (wr_eentry) eentry <= csr_wdata_i[31:6];
            if (wr_save)   save[csr_waddr_i[1:0]] <= csr_wdata_i;
            if (wr_llbctl) klo    <= csr_wdata_i[2];

            if (llbit_we_i) llbit <= llbit_wdata_i;
            if (wr_llbctl && csr_wdata_i[1]) llbit <= 1'b0;

            if (ertn_en_i) begin
                crmd[2:0] <= prmd;
                if (klo) klo   <= 1'b0;
                else     llbit <= 1'b0;
            end

            if (excep_en_i) begin
                prmd      <= crmd[2:0];
                crmd[2:0] <= 3'b000;
                era       <= excep_pc_i;
                ecode     <= excep_ecode_i;
                esubcode  <= excep_esubcode_i;
                if (excep_badv_we_i) badv <= excep_badv_wdata_i;
            end

`ifdef CSR_TIMER_EN
            if (wr_tid) tid <= csr_wdata_i;
            if (wr_ticlr) timer_is <= 1'b0;
            // A TCFG write reloads the counter and masks an expiry in the same cycle.
            if (wr_tcfg) begin
                tcfg     <= csr_wdata_i;
                tval     <= {csr_wdata_i[31:2], 2'b00};
                timer_en <= csr_wdata_i[0];
            end else if (timer_en) begin
                if (tval == 32'h0) begin
                    timer_is <= 1'b1;
                    if (tcfg[1]) tval     <= {tcfg[31:2], 2'b00};
                    else         timer_en <= 1'b0;
                end else begin
                    tval <= tval - 32'h1;
                end
            end
`endif
        end
    end

    always_comb begin
        csr_rdata_o = 32'h0;
        case (csr_raddr_i)
            A_CRMD:   csr_rdata_o = {23'h0, crmd};
            A_PRMD:   csr_rdata_o = {29'h0, prmd};
            A_ECFG:   csr_rdata_o = {19'h0, ecfg};
            A_ESTAT:  csr_rdata_o = {1'b0, esubcode, ecode, 3'h0, is_all};
            A_ERA:    csr_rdata_o = era;
            A_BADV:   csr_rdata_o = badv;
            A_EENTRY: csr_rdata_o = {eentry, 6'h0};
            A_SAVE0:  csr_rdata_o = save[0];
            A_SAVE1:  csr_rdata_o = save[1];
            A_SAVE2:  csr_rdata_o = save[2];
            A_SAVE3:  csr_rdata_o = save[3];
`ifdef CSR_TIMER_EN
            A_TID:    csr_rdata_o = tid;
            A_TCFG:   csr_rdata_o = tcfg;
            A_TVAL:   csr_rdata_o = tval;
`endif
            A_LLBCTL: csr_rdata_o = {29'h0, klo, 1'b0, llbit};
            default:  csr_rdata_o = 32'h0;
        endcase
    end

    assign cpu_level_o   = crmd[1:0];
    assign int_req_o     = crmd[2] & |(is_all & ecfg);
    assign excep_entry_o = {eentry, 6'h0};
    assign ertn_pc_o     = era;
    assign llbit_o       = llbit;
endmodule

// File: tb/tb_csr_unit.sv
// Bench for csr_unit: directed scenarios, then random traffic checked against
// an address-indexed CSR model with per-address write masks.
`timescale 1ns/1ps
module tb_csr_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic [1:0]  cpu_level;
    logic        csr_we;
    logic [13:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        llbit_we, llbit_wdata;
    logic        excep_en;
    logic [5:0]  excep_ecode;
    logic [8:0]  excep_esubcode;
    logic [31:0] excep_pc;
    logic        excep_badv_we;
    logic [31:0] excep_badv_wdata;
    logic        ertn_en;
    logic [7:0]  hw_int;
    logic        int_req;
    logic [31:0] excep_entry, ertn_pc;
    logic        llbit;

    always #50 clk = ~clk;

    csr_unit dut (
        .clk(clk), .rst_n(rst_n),
        .csr_raddr_i(csr_raddr), .csr_rdata_o(csr_rdata), .cpu_level_o(cpu_level),
        .csr_we_i(csr_we), .csr_waddr_i(csr_waddr), .csr_wdata_i(csr_wdata),
        .llbit_we_i(llbit_we), .llbit_wdata_i(llbit_wdata),
        .excep_en_i(excep_en), .excep_ecode_i(excep_ecode), .excep_esubcode_i(excep_esubcode),
        .excep_pc_i(excep_pc), .excep_badv_we_i(excep_badv_we), .excep_badv_wdata_i(excep_badv_wdata),
        .ertn_en_i(ertn_en), .hw_int_i(hw_int), .int_req_o(int_req),
        .excep_entry_o(excep_entry), .ertn_pc_o(ertn_pc), .llbit_o(llbit)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: whole 32-bit CSR images by address, plus LLBit and timer counter.
    logic [31:0] r [0:127];
    logic        m_llbit;
    logic [31:0] m_tval;
    logic        m_ten;

    logic [13:0] addrs [0:17] = '{14'h00, 14'h01, 14'h04, 14'h05, 14'h06, 14'h07, 14'h0C,
                                  14'h30, 14'h31, 14'h32, 14'h33, 14'h40, 14'h41, 14'h42,
                                  14'h44, 14'h60, 14'h02, 14'h100};

    function automatic logic [31:0] wmask(input logic [13:0] a);
        case (a)
            14'h00: return 32'h0000_01FF;
            14'h01: return 32'h0000_0007;
            14'h04: return 32'h0000_1BFF;
            14'h05: return 32'h0000_0003;
            14'h06, 14'h07, 14'h30, 14'h31, 14'h32, 14'h33: return 32'hFFFF_FFFF;
            14'h0C: return 32'hFFFF_FFC0;
`ifdef CSR_TIMER_EN
            14'h40, 14'h41: return 32'hFFFF_FFFF;
`endif
            14'h60: return 32'h0000_0004;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] mread(input logic [13:0] a);
        if (a == 14'h60) return {29'h0, r[96][2], 1'b0, m_llbit};
`ifdef CSR_TIMER_EN
        if (a == 14'h42) return m_tval;
`endif
        if (wmask(a) != 32'h0) return r[a[6:0]];
        return 32'h0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 128; i++) r[i] = 32'h0;
        r[0] = 32'h8;
        m_llbit = 1'b0;
        m_tval = 32'h0;
        m_ten = 1'b0;
    endtask

    task automatic model_clk();
        logic [31:0] n [0:127];
        logic [31:0] m;
        logic nl;
        n = r;
        nl = m_llbit;
        m = wmask(csr_waddr);
        if (csr_we && m != 32'h0)
            n[csr_waddr[6:0]] = (r[csr_waddr[6:0]] & ~m) | (csr_wdata & m);
        n[5][9:2] = hw_int;
        if (llbit_we) nl = llbit_wdata;
        if (csr_we && csr_waddr == 14'h60 && csr_wdata[1]) nl = 1'b0;
        if (ertn_en) begin
            n[0][2:0] = r[1][2:0];
            if (r[96][2]) n[96][2] = 1'b0;
            else nl = 1'b0;
        end
        if (excep_en) begin
            n[1][2:0] = r[0][2:0];
            n[0][2:0] = 3'b000;
            n[6] = excep_pc;
            n[5][30:16] = {excep_esubcode, excep_ecode};
            if (excep_badv_we) n[7] = excep_badv_wdata;
        end
`ifdef CSR_TIMER_EN
        if (csr_we && csr_waddr == 14'h44 && csr_wdata[0]) n[5][11] = 1'b0;
        if (csr_we && csr_waddr == 14'h41) begin
            m_tval = {csr_wdata[31:2], 2'b00};
            m_ten = csr_wdata[0];
        end else if (m_ten) begin
            if (m_tval == 32'h0) begin
                n[5][11] = 1'b1;
                if (r[65][1]) m_tval = {r[65][31:2], 2'b00};
                else m_ten = 1'b0;
            end else begin
                m_tval = m_tval - 1;
            end
        end
`endif
        r = n;
        m_llbit = nl;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [13:0] a, output logic [31:0] v);
        csr_raddr = a;
        #1;
        v = csr_rdata;
    endtask

    task automatic check_rd(input logic [13:0] a);
        logic [31:0] v;
        rd(a, v);
        chk($sformatf("rd_%0h", a), v, mread(a));
    endtask

    task automatic sweep();
        for (int i = 0; i < 18; i++) check_rd(addrs[i]);
    endtask

    task automatic idle();
        csr_we = 0; csr_waddr = 0; csr_wdata = 0;
        llbit_we = 0; llbit_wdata = 0;
        excep_en = 0; excep_ecode = 0; excep_esubcode = 0; excep_pc = 0;
        excep_badv_we = 0; excep_badv_wdata = 0;
        ertn_en = 0; hw_int = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_clk();
        #1;
        chk("cpu_level", {30'h0, cpu_level}, {30'h0, r[0][1:0]});
        chk("int_req", {31'h0, int_req},
            {31'h0, r[0][2] & |(r[5][12:0] & r[4][12:0])});
        chk("excep_entry", excep_entry, r[12]);
        chk("ertn_pc", ertn_pc, r[6]);
        chk("llbit", {31'h0, llbit}, {31'h0, m_llbit});
        idle();
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d);
        csr_we = 1; csr_waddr = a; csr_wdata = d;
        tick();
    endtask

    initial begin
        logic [31:0] v;
        idle();
        csr_raddr = 0;
        rst_n = 0;
        model_reset();
        tick(); tick();
        rd(14'h0, v); chk("rst_crmd", v, 32'h8);
        chk("rst_level", {30'h0, cpu_level}, 32'h0);
        chk("rst_int", {31'h0, int_req}, 32'h0);
        chk("rst_llbit", {31'h0, llbit}, 32'h0);
        sweep();
        rst_n = 1;
        tick();

        // exception entry then return
        wr(14'h0, 32'h7);
        excep_en = 1; excep_ecode = 6'hB; excep_pc = 32'h1C00_0100;
        tick();
        rd(14'h0, v); chk("exc_crmd", v, 32'h0);
        rd(14'h1, v); chk("exc_prmd", v, 32'h7);
        rd(14'h6, v); chk("exc_era", v, 32'h1C00_0100);
        rd(14'h5, v); chk("exc_ecode", {26'h0, v[21:16]}, 32'hB);
        ertn_en = 1;
        tick();
        rd(14'h0, v); chk("ertn_crmd", v, 32'h7);
        sweep();

        // BADV update gated by badv_we
        excep_en = 1; excep_badv_we = 1; excep_badv_wdata = 32'h3;
        tick();
        rd(14'h7, v); chk("badv_we", v, 32'h3);
        excep_en = 1; excep_badv_we = 0; excep_badv_wdata = 32'hDEAD_BEEF;
        tick();
        rd(14'h7, v); chk("badv_hold", v, 32'h3);

        // LLBit vs ERTN with KLO clear / set
        llbit_we = 1; llbit_wdata = 1; tick();
        chk("llbit_set", {31'h0, llbit}, 32'h1);
        wr(14'h60, 32'h0);
        ertn_en = 1; tick();
        chk("ertn_klo0", {31'h0, llbit}, 32'h0);
        llbit_we = 1; llbit_wdata = 1; tick();
        wr(14'h60, 32'h4);
        ertn_en = 1; tick();
        chk("ertn_klo1", {31'h0, llbit}, 32'h1);
        rd(14'h60, v); chk("llbctl_klo_clr", v, 32'h1);
        wr(14'h60, 32'h2);
        chk("wcllb", {31'h0, llbit}, 32'h0);

        // exception beats a same-cycle CRMD write
        excep_en = 1; csr_we = 1; csr_waddr = 14'h0; csr_wdata = 32'h3;
        tick();
        rd(14'h0, v); chk("exc_vs_wr", v, 32'h0);

        // masks and unimplemented addresses
        wr(14'h2, 32'hFFFF_FFFF);
        rd(14'h2, v); chk("unimpl", v, 32'h0);
        wr(14'h4, 32'hFFFF_FFFF);
        rd(14'h4, v); chk("ecfg_mask", v, 32'h1BFF);
        wr(14'h0C, 32'hFFFF_FFFF);
        rd(14'h0C, v); chk("eentry_mask", v, 32'hFFFF_FFC0);
        wr(14'h0C, 32'h0);
        wr(14'h4, 32'h0);

`ifdef CSR_TIMER_EN
        wr(14'h4, 32'h800);
        wr(14'h0, 32'h4);
        wr(14'h41, 32'h13);
        rd(14'h42, v); chk("tval_load", v, 32'h10);
        for (int i = 1; i <= 16; i++) begin
            tick();
            rd(14'h42, v); chk("tval_cnt", v, 32'(16 - i));
        end
        rd(14'h5, v); chk("is11_pre", {31'h0, v[11]}, 32'h0);
        tick();
        rd(14'h5, v); chk("is11_set", {31'h0, v[11]}, 32'h1);
        rd(14'h42, v); chk("tval_reload", v, 32'h10);
        chk("int_req_tmr", {31'h0, int_req}, 32'h1);
        wr(14'h44, 32'h1);
        rd(14'h5, v); chk("ticlr", {31'h0, v[11]}, 32'h0);
        for (int i = 0; i < 15; i++) tick();
        rd(14'h42, v); chk("tval_zero", v, 32'h0);
        wr(14'h41, 32'h9);
        rd(14'h5, v); chk("tcfg_wins", {31'h0, v[11]}, 32'h0);
        rd(14'h42, v); chk("tval_load2", v, 32'h8);
        for (int i = 0; i < 9; i++) tick();
        rd(14'h5, v); chk("oneshot_set", {31'h0, v[11]}, 32'h1);
        tick(); tick();
        rd(14'h42, v); chk("oneshot_hold", v, 32'h0);
        wr(14'h44, 32'h1);
        wr(14'h41, 32'h13);
        for (int i = 0; i < 16; i++) tick();
        csr_we = 1; csr_waddr = 14'h44; csr_wdata = 32'h1;
        tick();
        rd(14'h5, v); chk("set_beats_clr", {31'h0, v[11]}, 32'h1);
        tick(); tick();
        rst_n = 0; tick();
        rst_n = 1; tick(); tick();
        rd(14'h42, v); chk("rst_disarm", v, 32'h0);
`else
        wr(14'h41, 32'h13);
        rd(14'h41, v); chk("notmr_tcfg", v, 32'h0);
        for (int i = 0; i < 20; i++) tick();
        rd(14'h42, v); chk("notmr_tval", v, 32'h0);
        rd(14'h5, v); chk("notmr_is11", {31'h0, v[11]}, 32'h0);
`endif
        sweep();

        // random traffic against the model
        for (int k = 0; k < 800; k++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            hw_int = 8'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                csr_we = 1;
                csr_waddr = addrs[$urandom_range(0, 17)];
                csr_wdata = (csr_waddr == 14'h41) ? 32'($urandom_range(0, 63)) : $urandom;
            end
            if (!(csr_we && csr_waddr == 14'h60 && csr_wdata[1])) begin
                llbit_we = ($urandom_range(0, 7) == 0);
                llbit_wdata = 1'($urandom);
            end
            excep_en = ($urandom_range(0, 9) == 0);
            excep_ecode = 6'($urandom);
            excep_esubcode = 9'($urandom);
            excep_pc = $urandom;
            excep_badv_we = 1'($urandom);
            excep_badv_wdata = $urandom;
            ertn_en = ($urandom_range(0, 9) == 0);
            tick();
            check_rd(addrs[$urandom_range(0, 17)]);
            check_rd(14'h5);
        end
        rst_n = 1;
        tick();
        sweep();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/csr_unit.md
# csr_unit

Control/status register file and exception-commit unit sitting directly downstream of the WB stage. Holds the LA32 privileged CSRs, applies exception entry and ERTN return atomically at WB commit, and supplies the CSR read data, privilege level, exception entry/return PCs and the pending-interrupt request back to the pipeline. Includes the stable timer and the LLBit.

## Interface
- No parameters.
- clk  in  1  core clock
- rst_n  in  1  synchronous, active-low reset
- csr_raddr_i  in  14  CSR read address from WB
- csr_rdata_o  out  32  combinational read data for csr_raddr_i
- cpu_level_o  out  2  CRMD.PLV
- csr_we_i  in  1  CSR write strobe (already gated by WB valid/excep/ertn)
- csr_waddr_i  in  14  CSR write address
- csr_wdata_i  in  32  CSR write data (already masked by WB for csrxchg)
- llbit_we_i  in  1  LLBit write strobe
- llbit_wdata_i  in  1  LLBit value
- excep_en_i  in  1  take exception this cycle
- excep_ecode_i  in  6  ESTAT.Ecode
- excep_esubcode_i  in  9  ESTAT.EsubCode
- excep_pc_i  in  32  faulting PC
- excep_badv_we_i  in  1  update BADV
- excep_badv_wdata_i  in  32  BADV value
- ertn_en_i  in  1  execute ERTN this cycle
- hw_int_i  in  8  hardware interrupt lines
- int_req_o  out  1  interrupt pending and enabled
- excep_entry_o  out  32  EENTRY
- ertn_pc_o  out  32  ERA
- llbit_o  out  1  current LLBit

## Operation
- Registers (addr: reset value): CRMD 0x0: 0x0000_0008 (DA=1, PLV=0, IE=0); PRMD 0x1: 0; ECFG 0x4: 0; ESTAT 0x5: 0; ERA 0x6: 0; BADV 0x7: 0; EENTRY 0xC: 0; SAVE0–3 0x30–0x33: 0; TID 0x40: 0; TCFG 0x41: 0; TVAL 0x42: 0; TICLR 0x44: reads 0; LLBCTL 0x60: 0 (ROLLB reads llbit).
- Unimplemented addresses read 0, writes ignored.
- Write masks: CRMD[8:0]; PRMD[2:0]; ECFG[12:0] minus bit 10; ESTAT[1:0] only; EENTRY[31:6]; TCFG[31:0]; TID all; TVAL read-only; LLBCTL bit1 (WCLLB: write 1 clears llbit) and bit2 (KLO).
- Exception (excep_en_i): PRMD.PPLV<=CRMD.PLV, PRMD.PIE<=CRMD.IE; CRMD.PLV<=0, CRMD.IE<=0; ERA<=excep_pc_i; ESTAT[21:16]<=ecode, ESTAT[30:22]<=esubcode; BADV<=excep_badv_wdata_i when excep_badv_we_i.
- ERTN (ertn_en_i): CRMD.PLV<=PRMD.PPLV, CRMD.IE<=PRMD.PIE; if LLBCTL.KLO=0 clear llbit, else clear KLO.
- Priority within a cycle: exception > ERTN > csr_we_i/llbit_we_i for any field both touch; non-overlapping fields update together.
- ESTAT.IS[9:2] registered from hw_int_i every cycle; IS[1:0] software; IS[11] timer.
- int_req_o = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]), combinational from registered state.
- Timer: TCFG write loads TVAL<={TCFG.InitVal[31:2],2'b00} and arms timer_en=TCFG.En. While armed, TVAL decrements by 1 per cycle. At TVAL==0 while armed: set ESTAT.IS[11]; if Periodic reload TVAL from InitVal, else timer_en<=0 and TVAL holds 0.
- TICLR write with bit0=1 clears IS[11].

## Timing
- All state updates on clk rising edge; reads combinational (same-cycle write not forwarded; WB sees old value).
- Outputs during/after reset: csr_rdata_o per reset values, cpu_level_o=0, int_req_o=0, excep_entry_o=0, ertn_pc_o=0, llbit_o=0.
- Exception/ERTN effects visible the cycle after the strobe.
- Timer expiry and TICLR clear in same cycle: set wins.
- TCFG write and TVAL==0 in same cycle: write wins, no IS[11] set.
- Reset asserted mid-countdown: timer disarmed, TVAL=0.

## Configuration
- CSR_TIMER_EN defined: TID/TCFG/TVAL/TICLR and timer logic present as above.
- Not defined: those addresses read 0, writes ignored, ESTAT.IS[11] constant 0, no counter logic.

## Test plan
- Reset, read CRMD -> 0x8; cpu_level_o=0; int_req_o=0.
- Write CRMD=0x7 (PLV3, IE1), raise excep_en_i with ecode=0xB, pc=0x1C00_0100 -> next cycle CRMD=0x0, PRMD=0x7, ERA=0x1C00_0100, ESTAT[21:16]=0xB; then ertn_en_i -> CRMD=0x7.
- Exception with badv_we=1, badv=0x0000_0003 -> BADV=0x3; exception with badv_we=0 -> BADV unchanged.
- TCFG=0x0000_0013 (InitVal 4, periodic, en) -> TVAL 0x10 counts to 0, IS[11] sets, TVAL reloads 0x10; with ECFG.LIE[11]=1, CRMD.IE=1 -> int_req_o=1; TICLR=1 -> IS[11]=0.
- llbit_we_i=1/wdata=1, KLO=0, ertn -> llbit_o=0; repeat with KLO=1 -> llbit_o=1, KLO=0.
- Simultaneous excep_en_i and csr_we_i to CRMD=0x3 -> CRMD.PLV=0, IE=0 (exception wins).
